// File: rtl/serial_adder.sv
// Digit-serial adder: captures two operands, adds DIGIT bits per cycle LSB-first, holds the result until it is accepted.
// Define SERIAL_ADDER_OVERFLOW_EN to add the two's-complement overflow output.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | adding one digit per cycle
// DONE  | result valid, waiting for out_ready
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT:0]     digit_res;
  logic [WIDTH-1:0]   sum_shift;

  assign digit_res = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

  // Result digits enter at the MSB end so the LSB digit lands at bit 0 after STEPS shifts.
  generate
    if (DIGIT == WIDTH) begin : g_shift_full
      assign sum_shift = digit_res[DIGIT-1:0];
    end else begin : g_shift_part
      assign sum_shift = {digit_res[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = input1;
          b_d     = input2;
          carry_d = carryin;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          a_msb_d = input1[WIDTH-1];
          b_msb_d = input2[WIDTH-1];
`endif
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = digit_res[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
`endif
    end
  end

  assign sum      = sum_q;
  assign carryout = carry_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow = (state_q == ST_DONE) && (a_msb_q == b_msb_q)
                 && (sum_q[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: instance 0 uses defaults (DIGIT=1), instance 1 uses DIGIT=4.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [2];
  logic       ir   [2];
  logic       ov   [2];
  logic       ordy [2];
  logic       ci   [2];
  logic       co   [2];
  logic [7:0] a    [2];
  logic [7:0] b    [2];
  logic [7:0] s    [2];
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       ovf  [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } res_t;
  res_t sb[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .input1(a[0]), .input2(b[0]), .carryin(ci[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s[0]), .carryout(co[0])
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ovf[0])
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .input1(a[1]), .input2(b[1]), .carryin(ci[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s[1]), .carryout(co[1])
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ovf[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction on unit u; hold = cycles of out_ready backpressure in DONE.
  task automatic do_op(input int u, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input int hold);
    int         lat;
    int         exp_lat;
    logic [8:0] full;
    res_t       e;
    logic [7:0] held_s;
    logic       held_c;
    logic       stable;
    exp_lat = (u == 0) ? 8 : 2;
    lat = 0;
    while (!ir[u] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("in_ready_idle", 32'(ir[u]), 1);
    a[u] = x; b[u] = y; ci[u] = c; iv[u] = 1'b1;
    full = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.s = full[7:0];
    e.c = full[8];
    e.v = (x[7] == y[7]) && (full[7] != x[7]);
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs and keep in_valid high: both must be ignored while busy.
    a[u] = 8'($urandom); b[u] = 8'($urandom); ci[u] = 1'($urandom);
    chk("in_ready_run", 32'(ir[u]), 0);
    lat = 0;
    while (!ov[u] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    held_s = s[u];
    held_c = co[u];
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (s[u] !== held_s || co[u] !== held_c || ov[u] !== 1'b1 || ir[u] !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) chk("done_hold_stable", 32'(stable), 1);
    iv[u] = 1'b0;
    ordy[u] = 1'b1;
    e = sb.pop_front();
    chk("sum", 32'(s[u]), 32'(e.s));
    chk("carryout", 32'(co[u]), 32'(e.c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("overflow", 32'(ovf[u]), 32'(e.v));
`endif
    @(posedge clk); #1;
    ordy[u] = 1'b0;
    chk("out_valid_after_hs", 32'(ov[u]), 0);
    chk("in_ready_after_hs", 32'(ir[u]), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0; ci[u] = 1'b0; a[u] = '0; b[u] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_in_ready", 32'(ir[u]), 1);
      chk("rst_out_valid", 32'(ov[u]), 0);
      chk("rst_sum", 32'(s[u]), 0);
      chk("rst_carryout", 32'(co[u]), 0);
    end
    rst = 1'b0;

    // First op is offered in the very cycle after reset release.
    do_op(0, 8'h00, 8'h00, 1'b0, 0);
    do_op(0, 8'hFF, 8'h01, 1'b0, 0);
    do_op(0, 8'hFF, 8'hFF, 1'b1, 5);
    do_op(1, 8'h5A, 8'h3C, 1'b1, 0);
    do_op(1, 8'hFF, 8'h01, 1'b0, 3);
    do_op(0, 8'h7F, 8'h01, 1'b0, 0);
    do_op(0, 8'h80, 8'h80, 1'b0, 0);

    // Abort at RUN step 3.
    a[0] = 8'h12; b[0] = 8'h34; ci[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(ir[0]), 1);
    chk("abort_sum_cleared", 32'(s[0]), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ov[0]) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_result", 32'(seen), 0);
    do_op(0, 8'h10, 8'h20, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), i);
      do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), i);
    end

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
